// File: rtl/fm_bram_reader_pkg.sv
// Shared constants, FSM state type and row-buffer type for the feature-map
// BRAM reader. The ReLU clamp option is selected with FM_READER_RELU_EN
// (see fm_row_unpack).
package fm_pkg;

    localparam int DATA_W      = 16;
    localparam int LANES       = 70;
    localparam int VALID_LANES = 10;
    localparam int NUM_ROWS    = 8;
    localparam int ADDR_W      = 5;
    localparam int RD_LAT      = 2;

    localparam int IDX_W  = 7;
    localparam int LANE_W = $clog2(VALID_LANES);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

    // WAIT lengths minus one. The first row waits RD_LAT-1 cycles; later rows
    // wait one extra cycle so every row slot is the same length as the first
    // (edge cycle + fetch + wait + stream).
    localparam logic [WAIT_W-1:0] FIRST_WAIT = WAIT_W'((RD_LAT >= 2) ? RD_LAT - 2 : 0);
    localparam logic [WAIT_W-1:0] ROW_WAIT   = WAIT_W'(RD_LAT - 1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VALID_LANES - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_STREAM,
        S_DONE
    } fm_state_t;

    typedef logic [VALID_LANES-1:0][DATA_W-1:0] fm_row_t;

    // Flat word index of a lane within the pass.
    function automatic logic [IDX_W-1:0] fm_index(input logic [ROW_W-1:0]  r,
                                                  input logic [LANE_W-1:0] l);
        return IDX_W'(r) * IDX_W'(VALID_LANES) + IDX_W'(l);
    endfunction

endpackage

// File: rtl/fm_bram_reader_if.sv
// Word stream from the feature-map reader to the fully-connected layer.
interface fm_bram_reader_if;
    import fm_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;

    modport master (output out_valid, out_data, out_index, out_last,
                    input  out_ready);
    modport slave  (input  out_valid, out_data, out_index, out_last,
                    output out_ready);
endinterface

// File: rtl/fm_bram_reader_unpack.sv
// Row buffer and lane multiplexer. Only the low VALID_LANES lanes of the BRAM
// word are kept. With FM_READER_RELU_EN defined, negative lanes are clamped to
// zero as they are captured.
module fm_row_unpack
    import fm_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      capture,
    input  logic [LANES*DATA_W-1:0]   doutb,
    input  logic [LANE_W-1:0]         lane,
    output logic [DATA_W-1:0]         data
);

    fm_row_t buf_q;

    function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W-1:0] v);
`ifdef FM_READER_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Capture the populated lanes of the fetched row.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else if (capture) begin
            for (int i = 0; i < VALID_LANES; i++) begin
                buf_q[i] <= clamp(doutb[i*DATA_W +: DATA_W]);
            end
        end
    end

    // Present the lane currently being offered downstream.
    always_comb begin
        data = buf_q[lane];
    end

endmodule

// File: rtl/fm_bram_reader.sv
// Streams the pooled feature map out of fm_bram one 16-bit lane per
// handshake, ending each pass with a sticky finish flag.
// Optional ReLU clamp: FM_READER_RELU_EN.
//
// state  | meaning
// IDLE   | waiting for a rising edge of fm_read_en
// FETCH  | BRAM enable + row address for one cycle
// WAIT   | down-count until the row word is on doutb, capture on terminal count
// STREAM | offer lanes of the buffered row, advance on each transfer
// DONE   | pass complete, finish held until the next rising edge
module fm_bram_reader
    import fm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fm_read_en,
    output logic                     fm_bram_enb,
    output logic [ADDR_W-1:0]        fm_bram_addrb,
    input  logic [LANES*DATA_W-1:0]  fm_bram_doutb,
    fm_bram_reader_if.master         out_if,
    output logic                     fm_read_finish
);

    fm_state_t         state;
    logic              en_d;
    logic              en_p;
    logic [ROW_W-1:0]  row;
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lane_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              capture;
    logic              valid_q;
    logic              last_q;
    logic [IDX_W-1:0]  index_q;
    logic [DATA_W-1:0] lane_data;

    // Enable history is deliberately not cleared by reset, so an enable held
    // high through reset does not look like a fresh rising edge afterwards.
    always_ff @(posedge clk) begin
        en_d <= fm_read_en;
    end

    // Rising-edge detect, next lane and capture strobe.
    always_comb begin
        en_p    = fm_read_en & ~en_d;
        lane_nx = lane + 1'b1;
        capture = (state == S_WAIT) && (wait_cnt == '0);
    end

    // Sequencer with registered BRAM and stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            row            <= '0;
            lane           <= '0;
            wait_cnt       <= '0;
            fm_bram_enb    <= 1'b0;
            fm_bram_addrb  <= '0;
            valid_q        <= 1'b0;
            last_q         <= 1'b0;
            index_q        <= '0;
            fm_read_finish <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (en_p) begin
                        state          <= S_FETCH;
                        row            <= '0;
                        lane           <= '0;
                        fm_bram_enb    <= 1'b1;
                        fm_bram_addrb  <= '0;
                        fm_read_finish <= 1'b0;
                    end
                end
                S_FETCH: begin
                    fm_bram_enb <= 1'b0;
                    if (!fm_read_en) begin
                        state <= S_IDLE;
                    end else begin
                        state    <= S_WAIT;
                        wait_cnt <= (row == '0) ? FIRST_WAIT : ROW_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!fm_read_en) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == '0) begin
                        state   <= S_STREAM;
                        valid_q <= 1'b1;
                        index_q <= fm_index(row, lane);
                        last_q  <= (row == LAST_ROW) && (lane == LAST_LANE);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_STREAM: begin
                    if (!fm_read_en) begin
                        state   <= S_IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (out_if.out_ready) begin
                        if (lane != LAST_LANE) begin
                            lane    <= lane_nx;
                            index_q <= fm_index(row, lane_nx);
                            last_q  <= (row == LAST_ROW) && (lane_nx == LAST_LANE);
                        end else if (row != LAST_ROW) begin
                            state         <= S_FETCH;
                            row           <= row + 1'b1;
                            lane          <= '0;
                            valid_q       <= 1'b0;
                            last_q        <= 1'b0;
                            fm_bram_enb   <= 1'b1;
                            fm_bram_addrb <= ADDR_W'(row) + ADDR_W'(1);
                        end else begin
                            state          <= S_DONE;
                            valid_q        <= 1'b0;
                            last_q         <= 1'b0;
                            fm_read_finish <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fm_row_unpack u_unpack (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .doutb   (fm_bram_doutb),
        .lane    (lane),
        .data    (lane_data)
    );

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = lane_data;
    assign out_if.out_index = index_q;
    assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_fm_bram_reader.sv
// Directed bench for fm_bram_reader: cycle table for start-up latency and the
// row bubble, then hand-written pass, backpressure, abort, reset and ReLU runs.
module tb_fm_bram_reader;
    import fm_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    fm_read_en;
    logic                    fm_bram_enb;
    logic [ADDR_W-1:0]       fm_bram_addrb;
    logic [LANES*DATA_W-1:0] fm_bram_doutb;
    logic                    fm_read_finish;
    logic [LANES*DATA_W-1:0] mem [NUM_ROWS];

    int n_checks = 0;
    int n_fail   = 0;

    fm_bram_reader_if sif();

    fm_bram_reader dut (
        .clk            (clk),
        .rst            (rst),
        .fm_read_en     (fm_read_en),
        .fm_bram_enb    (fm_bram_enb),
        .fm_bram_addrb  (fm_bram_addrb),
        .fm_bram_doutb  (fm_bram_doutb),
        .out_if         (sif),
        .fm_read_finish (fm_read_finish)
    );

    always #5 clk = ~clk;

    // BRAM model: data for an enabled address is on doutb one edge later.
    always @(posedge clk) begin
        if (fm_bram_enb) fm_bram_doutb <= mem[fm_bram_addrb];
    end

    typedef struct {
        logic        en;
        logic        rdy;
        logic        enb;
        logic [4:0]  addr;
        logic        valid;
        logic [6:0]  idx;
        logic [15:0] data;
    } vec_t;

    vec_t vtab [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input int n);
        return 16'((n / 10) * 256 + (n % 10));
    endfunction

    task automatic fill_mem();
        for (int r = 0; r < NUM_ROWS; r++)
            for (int l = 0; l < LANES; l++)
                mem[r][l*16 +: 16] = (l < 10) ? 16'(r * 256 + l) : 16'hDEAD;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enb"},    fm_bram_enb,    0);
        check({tag, "_addr"},   fm_bram_addrb,  0);
        check({tag, "_valid"},  sif.out_valid,  0);
        check({tag, "_data"},   sif.out_data,   0);
        check({tag, "_index"},  sif.out_index,  0);
        check({tag, "_last"},   sif.out_last,   0);
        check({tag, "_finish"}, fm_read_finish, 0);
    endtask

    // Caller raises fm_read_en in the current cycle (T); cycle numbers are T+cyc.
    task automatic run_pass(input bit bp, output int first_cyc, output int last_cyc);
        int n = 0;
        int cyc = 0;
        bit stall = 0;
        logic [15:0] sd;
        logic [6:0]  si;
        logic        sl;
        first_cyc = -1;
        last_cyc  = -1;
        while (n < 80 && cyc < 400) begin
            tick();
            cyc++;
            sif.out_ready = bp ? cyc[0] : 1'b1;
            if (cyc == 1) begin
                check("start_enb",    fm_bram_enb,    1);
                check("start_addr",   fm_bram_addrb,  0);
                check("start_finish", fm_read_finish, 0);
            end
            if (stall) begin
                check("stall_valid", sif.out_valid, 1);
                check("stall_data",  sif.out_data,  sd);
                check("stall_index", sif.out_index, si);
                check("stall_last",  sif.out_last,  sl);
                stall = 0;
            end
            if (sif.out_valid && first_cyc < 0) first_cyc = cyc;
            if (sif.out_valid && sif.out_ready) begin
                check("word_index", sif.out_index, n);
                check("word_data",  sif.out_data,  exp_word(n));
                check("word_last",  sif.out_last,  (n == 79));
                if (n == 79) begin
                    check("finish_before_end", fm_read_finish, 0);
                    last_cyc = cyc;
                end
                n++;
            end else if (sif.out_valid) begin
                stall = 1;
                sd = sif.out_data;
                si = sif.out_index;
                sl = sif.out_last;
            end
        end
        if (n < 80) check("pass_timeout_words", n, 80);
        tick();
        check("finish_after_end", fm_read_finish, 1);
        check("valid_after_end",  sif.out_valid,  0);
    endtask

    initial begin
        int fc, lc, k;
        logic [15:0] relu_exp;

        // Start-up, first row, row bubble, first word of row 1.
        vtab[0]  = '{1, 1, 1, 0, 0, 0, 16'h0000};
        vtab[1]  = '{1, 1, 0, 0, 0, 0, 16'h0000};
        vtab[2]  = '{1, 0, 0, 0, 1, 0, 16'h0000};
        vtab[3]  = '{1, 0, 0, 0, 1, 0, 16'h0000};
        for (int i = 4; i < 13; i++)
            vtab[i] = '{1, 1, 0, 0, 1, 7'(i - 3), 16'(i - 3)};
        vtab[13] = '{1, 1, 1, 1, 0, 0, 16'h0000};
        vtab[14] = '{1, 1, 0, 0, 0, 0, 16'h0000};
        vtab[15] = '{1, 1, 0, 0, 0, 0, 16'h0000};
        vtab[16] = '{1, 1, 0, 0, 1, 10, 16'h0100};

        rst = 1'b1;
        fm_read_en = 1'b0;
        sif.out_ready = 1'b0;
        fill_mem();
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 17; i++) begin
            fm_read_en    = vtab[i].en;
            sif.out_ready = vtab[i].rdy;
            tick();
            check($sformatf("vec%0d_enb", i),   fm_bram_enb,   vtab[i].enb);
            check($sformatf("vec%0d_valid", i), sif.out_valid, vtab[i].valid);
            if (vtab[i].enb)
                check($sformatf("vec%0d_addr", i), fm_bram_addrb, vtab[i].addr);
            if (vtab[i].valid) begin
                check($sformatf("vec%0d_index", i), sif.out_index, vtab[i].idx);
                check($sformatf("vec%0d_data", i),  sif.out_data,  vtab[i].data);
            end
        end

        // Abort while word 25 is offered.
        k = 0;
        while (!(sif.out_valid && sif.out_index == 25) && k < 60) begin
            tick();
            k++;
        end
        check("abort_reach_25", sif.out_index, 25);
        fm_read_en = 1'b0;
        tick();
        check("abort_valid",  sif.out_valid,  0);
        check("abort_finish", fm_read_finish, 0);
        repeat (2) tick();
        check("abort_idle_valid", sif.out_valid, 0);
        check("abort_idle_enb",   fm_bram_enb,   0);

        // Restart after abort, no backpressure, check pass timing.
        fm_read_en = 1'b1;
        run_pass(1'b0, fc, lc);
        check("first_valid_cycle", fc, 3);
        check("pass_cycles", lc + 1, 104);

        // Enable held high in DONE: no restart.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("done_hold_finish", fm_read_finish, 1);
            check("done_hold_valid",  sif.out_valid,  0);
            check("done_hold_enb",    fm_bram_enb,    0);
        end

        // New rising edge restarts from DONE, with backpressure.
        fm_read_en = 1'b0;
        tick();
        fm_read_en = 1'b1;
        run_pass(1'b1, fc, lc);

        // Reset while word 40 is offered.
        fm_read_en = 1'b0;
        tick();
        fm_read_en = 1'b1;
        sif.out_ready = 1'b1;
        k = 0;
        while (!(sif.out_valid && sif.out_index == 40) && k < 200) begin
            tick();
            k++;
        end
        check("rst_reach_40", sif.out_index, 40);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_valid", sif.out_valid, 0);
            check("post_rst_enb",   fm_bram_enb,   0);
        end

        // Clamp behaviour on negative lanes.
        fm_read_en = 1'b0;
        mem[0][0*16 +: 16] = 16'hFFF0;
        mem[0][1*16 +: 16] = 16'h7FFF;
        mem[0][2*16 +: 16] = 16'h8000;
        tick();
        fm_read_en = 1'b1;
        k = 0;
        while (!sif.out_valid && k < 10) begin
            tick();
            k++;
        end
        check("relu_valid", sif.out_valid, 1);
`ifdef FM_READER_RELU_EN
        relu_exp = 16'h0000;
`else
        relu_exp = 16'hFFF0;
`endif
        check("relu_lane0", sif.out_data, relu_exp);
        tick();
        check("relu_lane1", sif.out_data, 16'h7FFF);
        tick();
`ifdef FM_READER_RELU_EN
        relu_exp = 16'h0000;
`else
        relu_exp = 16'h8000;
`endif
        check("relu_lane2", sif.out_data, relu_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
